// File: rtl/m_ram_param.sv
// Parametrised single-clock RAM written from debounced push buttons.
// It has a registered read port, an optional auto-increment pointer and a one-shot clear sweep.

module m_ram_param_btn (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic pulse
);
    logic [1:0] sync;
    logic       deb;
    logic       deb_q;

    // deb only moves on prescaler ticks, so bounces shorter than a tick period are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            if (tick)
                deb <= sync[1];
            deb_q <= deb;
        end
    end

    assign pulse = deb & ~deb_q;
endmodule

module m_ram_param #(
    parameter int DW      = 4,
    parameter int AW      = 6,
    parameter int DB_BITS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] adr_in,
    input  logic [DW-1:0] wdata,
    input  logic          mode,
    input  logic          we_btn,
    input  logic          inc_btn,
    input  logic          clr_btn,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] cur_adr,
    output logic          busy,
    output logic          wr_pulse
);
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam int NUM_BTN = 3;

    state_t               state;
    logic [DB_BITS-1:0]   presc;
    logic                 tick;
    logic [NUM_BTN-1:0]   raw_btn;
    logic [NUM_BTN-1:0]   pulse_btn;
    logic [AW-1:0]        ptr;
    logic [AW-1:0]        idx;
    logic [DW-1:0]        mem [0:(1<<AW)-1];
    logic                 we_p, inc_p, clr_p;
    logic                 wr_go, inc_go, clr_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    assign tick    = &presc;
    assign raw_btn = {clr_btn, inc_btn, we_btn};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        m_ram_param_btn u_btn (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .raw   (raw_btn[g]),
            .pulse (pulse_btn[g])
        );
    end

    assign {clr_p, inc_p, we_p} = pulse_btn;

    assign cur_adr = mode ? ptr : adr_in;

    // Clear wins over write/inc in the same cycle; a write plus an inc advances the pointer only once
    assign clr_go   = (state == S_IDLE) & clr_p;
    assign wr_go    = (state == S_IDLE) & we_p & ~clr_p;
    assign inc_go   = (state == S_IDLE) & ~clr_p & (inc_p | (we_p & mode));
    assign wr_pulse = wr_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ptr   <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            rdata <= '0;
        end else begin
            rdata <= mem[cur_adr];
            case (state)
                S_IDLE: begin
                    if (clr_go) begin
                        state <= S_CLEAR;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end else if (inc_go) begin
                        ptr <= ptr + 1'b1;
                    end
                end
                S_CLEAR: begin
                    idx <= idx + 1'b1;
                    if (&idx) begin
                        state <= S_IDLE;
                        ptr   <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage has no reset; an aborted sweep leaves the uncleared words intact
    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            mem[idx] <= '0;
        else if (wr_go)
            mem[cur_adr] <= wdata;
    end
endmodule

// File: tb/tb_m_ram_param.sv
// Directed and randomized bench for m_ram_param, using a word-array and pointer reference model.
// Button presses are long enough that each debounced press yields one event.

module tb_m_ram_param;
    localparam int DW  = 4;
    localparam int AW  = 6;
    localparam int DBB = 2;
    localparam int DEP = 64;
    localparam int GAP = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] adr_in;
    logic [DW-1:0] wdata;
    logic          mode;
    logic          we_btn, inc_btn, clr_btn;
    logic [DW-1:0] rdata;
    logic [AW-1:0] cur_adr;
    logic          busy;
    logic          wr_pulse;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] mdl [DEP];
    int            ptr_m;

    m_ram_param #(.DW(DW), .AW(AW), .DB_BITS(DBB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .adr_in   (adr_in),
        .wdata    (wdata),
        .mode     (mode),
        .we_btn   (we_btn),
        .inc_btn  (inc_btn),
        .clr_btn  (clr_btn),
        .rdata    (rdata),
        .cur_adr  (cur_adr),
        .busy     (busy),
        .wr_pulse (wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise the selected buttons, hold, release, then idle; count write strobes.
    // rd1/rd2 are rdata one and two cycles after the strobe cycle.
    task automatic press(input logic w, input logic i, input logic c, input int hold,
                         output int pulses, output logic [DW-1:0] rd1, output logic [DW-1:0] rd2);
        int grab;
        pulses = 0; grab = 0; rd1 = '0; rd2 = '0;
        we_btn = w; inc_btn = i; clr_btn = c;
        for (int k = 0; k < hold + GAP; k++) begin
            @(negedge clk);
            if (grab == 2) begin rd2 = rdata; grab = 0; end
            if (grab == 1) begin rd1 = rdata; grab = 2; end
            if (wr_pulse) begin pulses++; grab = 1; end
            if (k == hold - 1) begin we_btn = 1'b0; inc_btn = 1'b0; clr_btn = 1'b0; end
        end
    endtask

    task automatic rd_chk(input string tag, input int a);
        mode = 1'b0;
        adr_in = 6'(a);
        @(negedge clk);
        chk(tag, 32'(rdata), 32'(mdl[a]));
    endtask

    task automatic fill(input logic [DW-1:0] d);
        int p;
        logic [DW-1:0] r1, r2;
        mode = 1'b0;
        wdata = d;
        for (int a = 0; a < DEP; a++) begin
            adr_in = 6'(a);
            press(1'b1, 1'b0, 1'b0, 10, p, r1, r2);
            chk("fill_pulse", 32'(p), 32'd1);
            mdl[a] = d;
        end
    endtask

    task automatic do_clear(input logic we_inside, output int bcyc, output int pulses);
        bcyc = 0; pulses = 0;
        clr_btn = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy) bcyc++;
            if (wr_pulse) pulses++;
            if (k == 8) clr_btn = 1'b0;
            if (we_inside && busy && bcyc == 2) we_btn = 1'b1;
            if (we_inside && busy && bcyc == 10) we_btn = 1'b0;
        end
        for (int a = 0; a < DEP; a++) mdl[a] = '0;
        ptr_m = 0;
    endtask

    initial begin
        int p, bc, t;
        logic [DW-1:0] r1, r2;

        rst_n = 1'b0; adr_in = '0; wdata = '0; mode = 1'b0;
        we_btn = 1'b0; inc_btn = 1'b0; clr_btn = 1'b0;
        ptr_m = 0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        mode = 1'b1;
        #1 chk("rst_ptr", 32'(cur_adr), 32'd0);
        mode = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // initial sweep gives the model a known memory image
        do_clear(1'b0, bc, p);
        chk("clr0_busy_len", 32'(bc), 32'd64);

        // manual-address write, read-before-write then new data
        mode = 1'b0; adr_in = 6'd5; wdata = 4'hA;
        press(1'b1, 1'b0, 1'b0, 20, p, r1, r2);
        mdl[5] = 4'hA;
        chk("man_one_pulse", 32'(p), 32'd1);
        chk("man_rd_old", 32'(r1), 32'd0);
        chk("man_rd_new", 32'(r2), 32'hA);
        rd_chk("man_adr6", 6);

        // pointer-mode writes
        mode = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wdata = 4'(k);
            press(1'b1, 1'b0, 1'b0, 12, p, r1, r2);
            chk("ptr_pulse", 32'(p), 32'd1);
            mdl[ptr_m] = 4'(k);
            ptr_m = (ptr_m + 1) % DEP;
        end
        chk("ptr_cur3", 32'(cur_adr), 32'd3);
        for (int a = 0; a < 3; a++) rd_chk("ptr_mem", a);

        // randomized mixed traffic against the model
        for (int k = 0; k < 30; k++) begin
            logic m;
            logic [AW-1:0] a, eff;
            logic [DW-1:0] d;
            int op;
            m = 1'($urandom_range(1));
            a = 6'($urandom_range(63));
            d = 4'($urandom_range(15));
            op = $urandom_range(2);
            mode = m; adr_in = a; wdata = d;
            eff = m ? 6'(ptr_m) : a;
            press(op != 1, op != 0, 1'b0, 12, p, r1, r2);
            if (op != 1) mdl[eff] = d;
            if (op != 0 || m) ptr_m = (ptr_m + 1) % DEP;
            chk("rnd_pulse", 32'(p), (op != 1) ? 32'd1 : 32'd0);
            chk("rnd_cur", 32'(cur_adr), m ? 32'(ptr_m) : 32'(a));
        end
        for (int a = 0; a < DEP; a++) rd_chk("rnd_mem", a);

        // full clear with a write press buried inside the sweep
        fill(4'hF);
        do_clear(1'b1, bc, p);
        chk("clr_busy_len", 32'(bc), 32'd64);
        chk("clr_no_write", 32'(p), 32'd0);
        mode = 1'b1;
        #1 chk("clr_ptr0", 32'(cur_adr), 32'd0);
        for (int a = 0; a < DEP; a++) rd_chk("clr_mem", a);

        // pointer wrap and simultaneous write+inc
        mode = 1'b1;
        for (int k = 0; k < 64; k++) press(1'b0, 1'b1, 1'b0, 10, p, r1, r2);
        chk("wrap64", 32'(cur_adr), 32'd0);
        for (int k = 0; k < 63; k++) press(1'b0, 1'b1, 1'b0, 10, p, r1, r2);
        chk("ptr63", 32'(cur_adr), 32'd63);
        wdata = 4'h9;
        press(1'b1, 1'b1, 1'b0, 12, p, r1, r2);
        mdl[63] = 4'h9;
        chk("both_pulse", 32'(p), 32'd1);
        chk("both_wrap", 32'(cur_adr), 32'd0);
        rd_chk("both_mem63", 63);
        rd_chk("both_mem62", 62);

        // reset ten cycles into a sweep
        fill(4'hF);
        clr_btn = 1'b1;
        t = 0;
        while (!busy && t < 30) begin @(negedge clk); t++; end
        chk("abort_busy_seen", 32'(busy), 32'd1);
        clr_btn = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        chk("abort_wr_pulse", 32'(wr_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 10; a++) mdl[a] = '0;
        for (int a = 0; a < DEP; a++) rd_chk("abort_mem", a);

        // bouncing write button
        mode = 1'b0; adr_in = 6'd7; wdata = 4'h5;
        we_btn = 1'b1; @(negedge clk);
        we_btn = 1'b0; @(negedge clk);
        press(1'b1, 1'b0, 1'b0, 20, p, r1, r2);
        mdl[7] = 4'h5;
        chk("bounce_one_pulse", 32'(p), 32'd1);
        chk("bounce_rd", 32'(r2), 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
